router_pkt_ctrl: RTL

ROUTER_PKT_CTRL -- requirements
Module: router_pkt_ctrl

---
 rtl/router_pkt_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/router_pkt_ctrl.sv
// router_pkt_ctrl: packet router FSM with idle-FIFO soft resets; optional parity check via ROUTER_PARITY_CHK_EN.
module router_pkt_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_en,
    output logic       busy,
    output logic [2:0] write_en,
    output logic [7:0] fifo_din,
    output logic       lfd,
    output logic [2:0] soft_rst,
    output logic [2:0] vld_out,
    output logic       err
);
    localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd1;
    localparam logic [2:0] LOAD_FIRST_DATA    = 3'd2;
    localparam logic [2:0] LOAD_DATA          = 3'd3;
    localparam logic [2:0] FIFO_FULL_STATE    = 3'd4;
    localparam logic [2:0] CHECK_PARITY_ERROR = 3'd5;
    logic [2:0] state, state_nxt;
    logic [1:0] addr;
    logic [7:0] header;
    logic [4:0] idle_cnt [3];
    logic       accept, abort, full_a, wr;
    assign vld_out = ~fifo_empty;
    assign full_a  = fifo_full[addr];
    assign accept  = (state == DECODE_ADDRESS) && pkt_valid && (data_in[1:0] != 2'd3);
    assign abort   = (state != DECODE_ADDRESS) && soft_rst[addr];
    assign wr      = !abort && ((state == LOAD_FIRST_DATA) || (state == LOAD_DATA && !full_a));
    assign write_en = wr ? (3'b001 << addr) : 3'b000;
    assign fifo_din = (state == LOAD_FIRST_DATA) ? header : data_in;
    assign lfd      = wr && (state == LOAD_FIRST_DATA);
    assign busy     = !((state == DECODE_ADDRESS) || (state == LOAD_DATA && !full_a));
    // next-state decode; a soft reset of the active FIFO overrides every other transition
    always_comb begin
        state_nxt = state;
        case (state)
            DECODE_ADDRESS:     state_nxt = accept ? (fifo_empty[data_in[1:0]] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY) : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:    state_nxt = fifo_empty[addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:    state_nxt = LOAD_DATA;
            LOAD_DATA:          state_nxt = full_a ? FIFO_FULL_STATE : (pkt_valid ? LOAD_DATA : CHECK_PARITY_ERROR);
            FIFO_FULL_STATE:    state_nxt = full_a ? FIFO_FULL_STATE : LOAD_DATA;
            CHECK_PARITY_ERROR: state_nxt = DECODE_ADDRESS;
            default:            state_nxt = DECODE_ADDRESS;
        endcase
        if (abort) state_nxt = DECODE_ADDRESS;
    end
    // state register plus header/destination capture on header accept
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= DECODE_ADDRESS;
            addr   <= 2'd0;
            header <= 8'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr   <= data_in[1:0];
                header <= data_in;
            end
        end
    end
    // per-FIFO idle watchdog: 30 unread cycles with data pending fire a one-cycle soft reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst || !vld_out[i] || read_en[i]) begin
                idle_cnt[i] <= 5'd0;
                soft_rst[i] <= 1'b0;
            end else if (idle_cnt[i] == 5'd29) begin
                idle_cnt[i] <= 5'd0;
                soft_rst[i] <= 1'b1;
            end else begin
                idle_cnt[i] <= idle_cnt[i] + 5'd1;
                soft_rst[i] <= 1'b0;
            end
        end
    end
`ifdef ROUTER_PARITY_CHK_EN
    logic [7:0] parity;
    // running XOR seeded with the header; folding in the parity byte leaves zero on a good packet
    always_ff @(posedge clk) begin
        if (!rst) begin
            parity <= 8'd0;
            err    <= 1'b0;
        end else if (accept) begin
            parity <= data_in;
            err    <= 1'b0;
        end else if (wr && state == LOAD_DATA) begin
            parity <= parity ^ data_in;
        end else if (state == CHECK_PARITY_ERROR && !abort) begin
            err <= |parity;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule
